cla_pipe_adder: RTL



---
 rtl/cla_pipe_adder_pkg.sv | 12 +
 rtl/add1pg.sv | 15 +
 rtl/cla_group.sv | 45 ++++
 rtl/cla_pipe_adder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_adder_pkg.sv
// Shared defaults and configuration helpers for the pipelined CLA adder.
package cla_pipe_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_GROUP = 4;

    // A legal configuration splits WIDTH into whole lookahead groups.
    function automatic logic cfg_ok(input int width, input int group);
        return (group > 0) && (width > 0) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/add1pg.sv
// Single-bit propagate/generate cell feeding the lookahead tree.
module add1pg (
    input  logic a,
    input  logic b,
    output logic p,
    output logic g
);

    // Half-adder style p/g terms for one bit position.
    always_comb begin
        p = a ^ b;
        g = a & b;
    end

endmodule

// File: rtl/cla_group.sv
// N-bit carry-lookahead group: per-bit carries plus group propagate/generate.
// Used both on bit p/g (first level) and on group P/G (second level).
module cla_group
    import cla_pipe_adder_pkg::*;
#(
    parameter int N = DEF_GROUP
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] g,
    input  logic         cin,
    output logic [N-1:0] c,
    output logic         gp,
    output logic         gg
);

    logic t;
    logic pp;

    // Flat sum-of-products lookahead: every carry is built straight from
    // p/g/cin, no carry feeds another carry.
    always_comb begin
        c  = '0;
        gg = 1'b0;
        gp = &p;
        t  = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < N; i++) begin
            t  = 1'b0;
            pp = 1'b1;
            for (int k = i - 1; k >= 0; k--) begin
                t  = t | (pp & g[k]);
                pp = pp & p[k];
            end
            c[i] = t | (pp & cin);
        end
        t  = 1'b0;
        pp = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            t  = t | (pp & g[k]);
            pp = pp & p[k];
        end
        gg = t;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// S1 registers bit and group p/g; S2 resolves carries and registers the result.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    if (!cfg_ok(WIDTH, GROUP)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
    end

    // ---------------- operand prep ----------------
    logic [WIDTH-1:0] bb, p_in, g_in, unused_s1_c;
    logic [NG-1:0]    pg_in, gg_in;
    logic             c0_in;

    // Subtract is A + ~B + 1, so cin is overridden.
    always_comb begin
        bb    = sub ? ~b : b;
        c0_in = sub ? 1'b1 : cin;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        add1pg u_pg (.a(a[i]), .b(bb[i]), .p(p_in[i]), .g(g_in[i]));
    end

    // Group terms only; carries here assume cin=0 and are not needed.
    for (genvar j = 0; j < NG; j++) begin : g_s1_grp
        cla_group #(.N(GROUP)) u_grp (
            .p  (p_in[j*GROUP +: GROUP]),
            .g  (g_in[j*GROUP +: GROUP]),
            .cin(1'b0),
            .c  (unused_s1_c[j*GROUP +: GROUP]),
            .gp (pg_in[j]),
            .gg (gg_in[j])
        );
    end

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    logic s2_adv, s1_adv, accept;

    // Stall-based flow control: a stage moves when the one after it can take it.
    always_comb begin
        s2_adv   = !out_valid_q | out_ready;
        s1_adv   = s1_valid_q & s2_adv;
        in_ready = !s1_valid_q | s2_adv;
        accept   = in_valid & in_ready;
    end

    // ---------------- S1 ----------------
    logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
    logic [NG-1:0]    pg_q, pg_d, gg_q, gg_d;
    logic             c0_q, c0_d;

    // S1 loads on accept; an advance with no new bundle just empties it.
    always_comb begin
        p_d        = p_q;
        g_d        = g_q;
        pg_d       = pg_q;
        gg_d       = gg_q;
        c0_d       = c0_q;
        s1_valid_d = s1_valid_q;
        if (accept) begin
            p_d        = p_in;
            g_d        = g_in;
            pg_d       = pg_in;
            gg_d       = gg_in;
            c0_d       = c0_in;
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // S1 state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= '0;
            g_q        <= '0;
            pg_q       <= '0;
            gg_q       <= '0;
            c0_q       <= 1'b0;
            s1_valid_q <= 1'b0;
        end else begin
            p_q        <= p_d;
            g_q        <= g_d;
            pg_q       <= pg_d;
            gg_q       <= gg_d;
            c0_q       <= c0_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    // ---------------- S2 carry resolution ----------------
    logic [NG-1:0]    grp_c, unused_s2_gp, unused_s2_gg;
    logic [WIDTH-1:0] bit_c;
    logic             all_p, all_g, c_msb;

    // Second level: group carries from group P/G and the stage-1 carry-in.
    cla_group #(.N(NG)) u_lvl2 (
        .p  (pg_q),
        .g  (gg_q),
        .cin(c0_q),
        .c  (grp_c),
        .gp (all_p),
        .gg (all_g)
    );

    for (genvar j = 0; j < NG; j++) begin : g_s2_grp
        cla_group #(.N(GROUP)) u_grp (
            .p  (p_q[j*GROUP +: GROUP]),
            .g  (g_q[j*GROUP +: GROUP]),
            .cin(grp_c[j]),
            .c  (bit_c[j*GROUP +: GROUP]),
            .gp (unused_s2_gp[j]),
            .gg (unused_s2_gg[j])
        );
    end

    logic [WIDTH-1:0] sum_q, sum_d, sum_nx;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    // Result and flags; overflow compares carry into and out of the MSB.
    always_comb begin
        c_msb  = all_g | (all_p & c0_q);
        sum_nx = p_q ^ bit_c;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (s1_adv) begin
            sum_d  = sum_nx;
            cout_d = c_msb;
            ovf_d  = c_msb ^ bit_c[WIDTH-1];
            zero_d = (sum_nx == '0);
        end
        out_valid_d = out_valid_q;
        if (s1_adv)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
    end

    // Output register; holds steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
